// File: rtl/instr_encode_loader.sv
// Encodes instruction fields into 16-bit words and streams them into instruction memory; 1-cycle push-to-write latency when empty.
// in_ready drops when the word buffer is full or the address space is used up; optional immediate range check under ENC_RANGE_CHECK_EN.
module instr_encode_loader #(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              stop,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [2:0]        in_ra,
    input  logic [2:0]        in_rb,
    input  logic [2:0]        in_rd,
    input  logic [11:0]       in_imm,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic              err_range,
    output logic [ADDR_W:0]   words_written
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [ADDR_W:0]  WORD_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]  LAST_SLOT = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [15:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_push_addr;
    logic [ADDR_W:0]   r_words;
    logic              r_err_illegal;

    logic        w_full, w_empty, w_exhausted, w_accept, w_push, w_pop;
    logic        w_illegal, w_range_bad, w_start_go;
    logic [15:0] w_enc;

    assign w_full      = (r_count == CNT_FULL);
    assign w_empty     = (r_count == '0);
    // Top bit set means every address from base_addr up has a word assigned.
    assign w_exhausted = r_push_addr[ADDR_W];
    assign w_illegal   = (in_op == 4'hA);
    assign w_start_go  = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_accept    = in_valid && in_ready;
    assign w_push      = w_accept && !w_illegal && !w_range_bad;
    assign w_pop       = !w_empty && imem_ready;

    assign in_ready      = (r_state == S_RUN) && !w_full && !w_exhausted;
    assign imem_we       = !w_empty;
    assign imem_wdata    = w_empty ? 16'h0000 : r_mem[r_rd_ptr];
    assign imem_addr     = r_addr;
    assign busy          = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done          = (r_state == S_DONE);
    assign err_illegal   = r_err_illegal;
    assign words_written = r_words;

    always_comb begin
        w_enc = 16'h0000;
        case (in_op)
            4'd0, 4'd1, 4'd11, 4'd12: w_enc = {in_op, in_ra, in_rb, in_imm[5:0]};
            4'd2, 4'd3, 4'd4, 4'd5,
            4'd6, 4'd7, 4'd8, 4'd9:   w_enc = {in_op, in_ra, in_rb, in_rd, 3'b000};
            4'd13:                    w_enc = {in_op, in_imm};
            4'd14, 4'd15:             w_enc = {in_op, in_ra, 1'b0, in_imm[7:0]};
            default:                  w_enc = 16'h0000;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    logic r_err_range;

    always_comb begin
        w_range_bad = 1'b0;
        case (in_op)
            4'd0, 4'd1, 4'd11, 4'd12: w_range_bad = !((in_imm[11:5] == 7'h00) || (in_imm[11:5] == 7'h7F));
            4'd14, 4'd15:             w_range_bad = (in_imm[11:8] != 4'h0);
            default:                  w_range_bad = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || w_start_go) begin
            r_err_range <= 1'b0;
        end else if (w_accept && !w_illegal && w_range_bad) begin
            r_err_range <= 1'b1;
        end
    end

    assign err_range = r_err_range;
`else
    assign w_range_bad = 1'b0;
    assign err_range   = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (stop || (w_push && r_push_addr == LAST_SLOT)) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_empty) w_state_nxt = S_DONE;
            S_DONE:  if (start) w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_enc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_addr        <= '0;
            r_push_addr   <= '0;
            r_words       <= '0;
            r_err_illegal <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_go) begin
                r_addr        <= base_addr;
                r_push_addr   <= {1'b0, base_addr};
                r_words       <= '0;
                r_err_illegal <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr    <= r_wr_ptr + PTR_ONE;
                    r_push_addr <= r_push_addr + WORD_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_ONE;
                    r_words  <= r_words + WORD_ONE;
                    // Saturate at the top address instead of wrapping.
                    if (r_addr != {ADDR_W{1'b1}}) begin
                        r_addr <= r_addr + ADDR_ONE;
                    end
                end
                if (w_accept && w_illegal) begin
                    r_err_illegal <= 1'b1;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CNT_ONE;
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - CNT_ONE;
                end
            end
        end
    end
endmodule
